poly_sequencer: RTL and testbench
=================================

Name: poly_sequencer

Overview:
- Moore FSM that drives the 16-bit three-register datapath: constant mux, two operand muxes, add/sub unit, and regX/regS/regH.
- Replaces manual switch operation with automatic evaluation of Y = A*X^2 + B*X + C using Horner's form, ((A)*X + B)*X + C.
- Multiplication by X is done by repeated addition, so the datapath needs no multiplier.
- Result is left in regS, which the display block already shows.

Parameters:
- X_W, 3: width of the operand X and of the internal loop counter.
- SEL_W, 2: width of each mux select output.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request one evaluation; sampled in IDLE only.
- x_in  in  X_W  operand X; captured on the accepted start edge.
- x_out  out  X_W  captured X, wired to the regX data input.
- ld_x  out  1  regX load enable (datapath SW[9] role).
- ld_s  out  1  regS load enable (SW[8] role).
- ld_h  out  1  regH load enable (SW[7] role).
- sel_k  out  SEL_W  constant-mux select: 00=0, 01=A, 10=B, 11=C.
- sel_a  out  SEL_W  adder IN1 select: 00=const, 01=regX, 10=regS, 11=regH.
- sel_b  out  SEL_W  adder IN2 select: 00=regX, 01=const, 10=regS, 11=regH.
- sub  out  1  add/sub control; tied 0 in this sequence.
- busy  out  1  high from LOAD_X through ADDC.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; x_q=0; cnt=0.
  - Outputs in IDLE: all load enables 0, all selects 00, sub=0, busy=0, done=0, x_out=0.
- Outputs are decoded from the state register only (Moore). No output depends on start or x_in combinationally.
- Internal registers:
  - x_q (X_W): captured X.
  - cnt (X_W): loop down-counter.
  - rnd (1 bit): 0 = B round, 1 = C round.
- States, with the values driven in each:
  - IDLE: on start=1, x_q<=x_in, go to LOAD_X.
  - LOAD_X: ld_x=1 (regX<=x_q) -> CLR0.
  - CLR0: sel_k=00, sel_a=00, sel_b=01, ld_h=1 (H<=0) -> INIT.
  - INIT: sel_k=01, sel_a=11, sel_b=01, ld_s=1 (S<=H+A); rnd<=0 -> CLR.
  - CLR: H<=0 (same drive as CLR0); cnt<=x_q.
    - If x_q==0, go to ADDK; otherwise go to MAC.
  - MAC: sel_a=11, sel_b=10, ld_h=1 (H<=H+S); cnt<=cnt-1.
    - If cnt==1, go to ADDK; otherwise stay in MAC.
  - ADDK: sel_a=11, sel_b=01, ld_s=1 (S<=H+K).
    - sel_k=10 (B) when rnd=0, 11 (C) when rnd=1.
    - If rnd=0: rnd<=1, go to CLR. If rnd=1: go to DONE.
  - DONE: done=1, busy=0 -> IDLE unconditionally.
- Latency: start accepted at edge 0. busy is high for exactly 7+2*X cycles. done is asserted in the following cycle.
- Arithmetic: all sums are 16-bit and wrap mod 2^16 inside the datapath; the sequencer does no arithmetic on data.
- Start while busy or in DONE: ignored, with no queuing. A new start is accepted only from IDLE.
- start held high continuously: a new evaluation begins in the cycle after DONE. That is back-to-back with one IDLE cycle between runs.
- x_in changing after the accepted start: no effect on the run in progress.
- Reset mid-operation: immediate return to IDLE with all enables 0. regS holds a partial value, which is acceptable; no done pulse is produced.
- X=0: both MAC loops are skipped and the result is C.

Decomposition:
- Package poly_seq_pkg holds:
  - the state enum;
  - the select encodings SEL_K_{ZERO,A,B,C}, SEL_A_{CONST,X,S,H}, SEL_B_{X,CONST,S,H}.
- The datapath top imports the same package so both sides share the encodings.
- One sub-module, seq_down_counter:
  - X_W-bit, with load, decrement and is_one/is_zero flags;
  - drives cnt and the MAC exit condition.

Test Plan:
- Bench pairs the sequencer with a behavioural datapath model using A=2, B=2, C=1.
- Reset, then start with x_in=3:
  - busy high for 13 cycles, then done for 1 cycle;
  - regS=25 (0x0019);
  - exactly 6 MAC cycles observed.
- x_in=0:
  - busy for 7 cycles; regS=1;
  - no MAC state is visited;
  - sel_k in the two ADDK cycles is 10, then 11.
- x_in=7: busy for 21 cycles; regS=113 (0x0071).
- start pulsed again during MAC, and again during DONE, with x_in=5: both ignored; result stays 25 for the earlier X=3 run.
- rst_n low during the second MAC loop:
  - all enables drop asynchronously; state=IDLE; no done pulse;
  - a fresh start with x_in=2 then yields regS=13.
- start held high with x_in=1:
  - each run yields regS=5, with one IDLE cycle between DONE and LOAD_X;
  - throughout, at most one load enable is high per cycle and sub is never asserted.

Source files
------------

// File: rtl/poly_seq_pkg.sv
// Shared definitions for the polynomial sequencer and the datapath it drives.
// Keeping the mux encodings here means both sides agree on what each select
// code means without duplicating magic numbers.
package poly_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_X = 3'd1,
        S_CLR0   = 3'd2,
        S_INIT   = 3'd3,
        S_CLR    = 3'd4,
        S_MAC    = 3'd5,
        S_ADDK   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    // Constant mux: which coefficient is presented to the adder.
    localparam logic [1:0] SEL_K_ZERO  = 2'b00;
    localparam logic [1:0] SEL_K_A     = 2'b01;
    localparam logic [1:0] SEL_K_B     = 2'b10;
    localparam logic [1:0] SEL_K_C     = 2'b11;

    // Adder IN1 source.
    localparam logic [1:0] SEL_A_CONST = 2'b00;
    localparam logic [1:0] SEL_A_X     = 2'b01;
    localparam logic [1:0] SEL_A_S     = 2'b10;
    localparam logic [1:0] SEL_A_H     = 2'b11;

    // Adder IN2 source.
    localparam logic [1:0] SEL_B_X     = 2'b00;
    localparam logic [1:0] SEL_B_CONST = 2'b01;
    localparam logic [1:0] SEL_B_S     = 2'b10;
    localparam logic [1:0] SEL_B_H     = 2'b11;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter used to count the repeated additions that stand in
// for a multiply by X. Only the flags leave the block; the sequencer never
// needs the raw count.
module seq_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] din,
    output logic         is_one,
    output logic         is_zero
);

    logic [W-1:0] cnt;

    // Load takes priority so a fresh loop always starts from the captured X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= din;
        end else if (dec) begin
            cnt <= cnt - W'(1);
        end
    end

    assign is_one  = (cnt == W'(1));
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/poly_sequencer.sv
// Moore sequencer that evaluates Y = A*X^2 + B*X + C on the three-register
// add/sub datapath using Horner's form, with each multiply by X done as X
// repeated additions into regH. The final value is left in regS.
module poly_sequencer
    import poly_seq_pkg::*;
#(
    parameter int X_W   = 3,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [X_W-1:0]   x_in,
    output logic [X_W-1:0]   x_out,
    output logic             ld_x,
    output logic             ld_s,
    output logic             ld_h,
    output logic [SEL_W-1:0] sel_k,
    output logic [SEL_W-1:0] sel_a,
    output logic [SEL_W-1:0] sel_b,
    output logic             sub,
    output logic             busy,
    output logic             done
);

    state_t         state;
    state_t         state_nxt;
    logic [X_W-1:0] x_q;
    logic           rnd;
    logic           cnt_one;
    logic           cnt_zero;
    logic [1:0]     k_sel;
    logic [1:0]     a_sel;
    logic [1:0]     b_sel;

    // State register; reset always lands in IDLE so every enable drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // X is captured only on an accepted start so later x_in changes are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            x_q <= x_in;
        end
    end

    // Round flag: first ADDK adds B, second ADDK adds C and finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd <= 1'b0;
        end else if (state == S_INIT) begin
            rnd <= 1'b0;
        end else if ((state == S_ADDK) && !rnd) begin
            rnd <= 1'b1;
        end
    end

    seq_down_counter #(
        .W(X_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == S_CLR),
        .dec     (state == S_MAC),
        .din     (x_q),
        .is_one  (cnt_one),
        .is_zero (cnt_zero)
    );

    // Next-state and Moore output decode; everything defaults to the IDLE drive.
    always_comb begin
        state_nxt = state;
        ld_x      = 1'b0;
        ld_s      = 1'b0;
        ld_h      = 1'b0;
        k_sel     = SEL_K_ZERO;
        a_sel     = SEL_A_CONST;
        b_sel     = SEL_B_X;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD_X;
                end
            end
            S_LOAD_X: begin
                busy      = 1'b1;
                ld_x      = 1'b1;
                state_nxt = S_CLR0;
            end
            S_CLR0: begin
                busy      = 1'b1;
                b_sel     = SEL_B_CONST;
                ld_h      = 1'b1;
                state_nxt = S_INIT;
            end
            S_INIT: begin
                busy      = 1'b1;
                k_sel     = SEL_K_A;
                a_sel     = SEL_A_H;
                b_sel     = SEL_B_CONST;
                ld_s      = 1'b1;
                state_nxt = S_CLR;
            end
            S_CLR: begin
                busy      = 1'b1;
                b_sel     = SEL_B_CONST;
                ld_h      = 1'b1;
                state_nxt = (x_q == '0) ? S_ADDK : S_MAC;
            end
            S_MAC: begin
                busy      = 1'b1;
                a_sel     = SEL_A_H;
                b_sel     = SEL_B_S;
                ld_h      = 1'b1;
                // The zero check guards against a 2^X_W-long runaway loop.
                state_nxt = (cnt_one || cnt_zero) ? S_ADDK : S_MAC;
            end
            S_ADDK: begin
                busy      = 1'b1;
                k_sel     = rnd ? SEL_K_C : SEL_K_B;
                a_sel     = SEL_A_H;
                b_sel     = SEL_B_CONST;
                ld_s      = 1'b1;
                state_nxt = rnd ? S_DONE : S_CLR;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign sel_k = SEL_W'(k_sel);
    assign sel_a = SEL_W'(a_sel);
    assign sel_b = SEL_W'(b_sel);
    assign sub   = 1'b0;
    assign x_out = (state == S_IDLE) ? '0 : x_q;

endmodule

// File: tb/tb_poly_sequencer.sv
// Bench for poly_sequencer: the sequencer drives a behavioural model of the
// 16-bit three-register datapath, and results are compared with the
// polynomial computed directly from the coefficients.
module tb_poly_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] x_in;
    logic [2:0] x_out;
    logic       ld_x, ld_s, ld_h;
    logic [1:0] sel_k, sel_a, sel_b;
    logic       sub, busy, done;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] kA = 16'd2;
    logic [15:0] kB = 16'd2;
    logic [15:0] kC = 16'd1;
    logic [15:0] regX = 16'd0;
    logic [15:0] regS = 16'd0;
    logic [15:0] regH = 16'd0;

    logic       s_ldx, s_lds, s_ldh, s_sub;
    logic [1:0] s_selk, s_sela, s_selb;
    logic [2:0] s_xout;

    int         busyCnt, doneCnt, macCnt;
    int         onehotViol = 0;
    int         subSeen    = 0;
    logic [1:0] selkLog[$];

    always #5 clk = ~clk;

    poly_sequencer #(.X_W(3), .SEL_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x_in  (x_in),
        .x_out (x_out),
        .ld_x  (ld_x),
        .ld_s  (ld_s),
        .ld_h  (ld_h),
        .sel_k (sel_k),
        .sel_a (sel_a),
        .sel_b (sel_b),
        .sub   (sub),
        .busy  (busy),
        .done  (done)
    );

    // Snapshot controls mid-cycle and gather run statistics.
    always @(negedge clk) begin
        s_ldx  = ld_x;
        s_lds  = ld_s;
        s_ldh  = ld_h;
        s_sub  = sub;
        s_selk = sel_k;
        s_sela = sel_a;
        s_selb = sel_b;
        s_xout = x_out;
        if (busy) busyCnt++;
        if (done) doneCnt++;
        if (ld_h && (sel_b == 2'b10)) macCnt++;
        if (ld_s) selkLog.push_back(sel_k);
        if ((int'(ld_x) + int'(ld_s) + int'(ld_h)) > 1) onehotViol++;
        if (sub) subSeen++;
    end

    // Behavioural datapath: constant mux, operand muxes, add/sub, three registers.
    always @(posedge clk) begin
        logic [15:0] kv, in1, in2, sum;
        if (rst_n) begin
            case (s_selk)
                2'b00:   kv = 16'd0;
                2'b01:   kv = kA;
                2'b10:   kv = kB;
                default: kv = kC;
            endcase
            case (s_sela)
                2'b00:   in1 = kv;
                2'b01:   in1 = regX;
                2'b10:   in1 = regS;
                default: in1 = regH;
            endcase
            case (s_selb)
                2'b00:   in2 = regX;
                2'b01:   in2 = kv;
                2'b10:   in2 = regS;
                default: in2 = regH;
            endcase
            sum = s_sub ? (in1 - in2) : (in1 + in2);
            if (s_ldx) regX <= {13'd0, s_xout};
            if (s_lds) regS <= sum;
            if (s_ldh) regH <= sum;
        end
    end

    function automatic logic [15:0] poly(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input int x);
        logic [15:0] xv;
        xv = 16'(x);
        return a * xv * xv + b * xv + c;
    endfunction

    task automatic clear_stats();
        busyCnt = 0;
        doneCnt = 0;
        macCnt  = 0;
        selkLog.delete();
    endtask

    // One full evaluation; returns in IDLE one cycle after DONE.
    task automatic run_eval(input logic [2:0] x, output bit timedOut);
        clear_stats();
        start = 1'b1;
        x_in  = x;
        @(negedge clk); #1;
        start = 1'b0;
        x_in  = 3'($urandom);
        timedOut = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (doneCnt > 0) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        x_in  = 3'd0;
        #12;
        vectors++;
        if ({ld_x, ld_s, ld_h, sub} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_enables: got %b expected 0000", {ld_x, ld_s, ld_h, sub});
        end
        vectors++;
        if ({sel_k, sel_a, sel_b} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_selects: got %b expected 000000", {sel_k, sel_a, sel_b});
        end
        vectors++;
        if ({busy, done, x_out} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got %b expected 00000", {busy, done, x_out});
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_no_start: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_x3();
        bit to;
        run_eval(3'd3, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("[TB] FAIL x3_timeout: done got none expected pulse");
        end
        vectors++;
        if (busyCnt != 13) begin
            miscompares++;
            $display("[TB] FAIL x3_busy: got %0d expected 13", busyCnt);
        end
        vectors++;
        if (doneCnt != 1) begin
            miscompares++;
            $display("[TB] FAIL x3_done: got %0d expected 1", doneCnt);
        end
        vectors++;
        if (regS !== poly(kA, kB, kC, 3)) begin
            miscompares++;
            $display("[TB] FAIL x3_result: got %0d expected %0d", regS, poly(kA, kB, kC, 3));
        end
        vectors++;
        if (macCnt != 6) begin
            miscompares++;
            $display("[TB] FAIL x3_mac: got %0d expected 6", macCnt);
        end
    endtask

    task automatic test_x0();
        bit to;
        logic [5:0] seq;
        run_eval(3'd0, to);
        vectors++;
        if (busyCnt != 7) begin
            miscompares++;
            $display("[TB] FAIL x0_busy: got %0d expected 7", busyCnt);
        end
        vectors++;
        if (regS !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL x0_result: got %0d expected 1", regS);
        end
        vectors++;
        if (macCnt != 0) begin
            miscompares++;
            $display("[TB] FAIL x0_mac: got %0d expected 0", macCnt);
        end
        seq = 6'b111111;
        if (selkLog.size() == 3) seq = {selkLog[0], selkLog[1], selkLog[2]};
        vectors++;
        if (seq !== 6'b01_10_11) begin
            miscompares++;
            $display("[TB] FAIL x0_selk: got %b (n=%0d) expected 011011", seq, selkLog.size());
        end
    endtask

    task automatic test_x7();
        bit to;
        run_eval(3'd7, to);
        vectors++;
        if (busyCnt != 21) begin
            miscompares++;
            $display("[TB] FAIL x7_busy: got %0d expected 21", busyCnt);
        end
        vectors++;
        if (regS !== 16'h0071) begin
            miscompares++;
            $display("[TB] FAIL x7_result: got %0d expected 113", regS);
        end
    endtask

    task automatic test_ignored_start();
        bit pulsedMac  = 1'b0;
        bit pulsedDone = 1'b0;
        clear_stats();
        start = 1'b1;
        x_in  = 3'd3;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (doneCnt > 0) begin
                if (!pulsedDone) begin
                    start = 1'b1;
                    x_in  = 3'd5;
                    pulsedDone = 1'b1;
                end else begin
                    break;
                end
            end else if (macCnt > 0 && !pulsedMac) begin
                start = 1'b1;
                x_in  = 3'd5;
                pulsedMac = 1'b1;
            end
        end
        vectors++;
        if (regS !== 16'd25) begin
            miscompares++;
            $display("[TB] FAIL ignore_result: got %0d expected 25", regS);
        end
        vectors++;
        if (busyCnt != 13) begin
            miscompares++;
            $display("[TB] FAIL ignore_busy: got %0d expected 13", busyCnt);
        end
        repeat (5) begin
            @(negedge clk); #1;
        end
        vectors++;
        if (busyCnt != 13 || doneCnt != 1) begin
            miscompares++;
            $display("[TB] FAIL ignore_norun: busy %0d done %0d expected 13 1", busyCnt, doneCnt);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_stats();
        start = 1'b1;
        x_in  = 3'd3;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (macCnt >= 5) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ld_x, ld_s, ld_h, busy, done} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_async: got %b expected 00000", {ld_x, ld_s, ld_h, busy, done});
        end
        vectors++;
        if (macCnt != 5) begin
            miscompares++;
            $display("[TB] FAIL midreset_reach: mac got %0d expected 5", macCnt);
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        vectors++;
        if (doneCnt != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_nodone: done %0d busy %b expected 0 0", doneCnt, busy);
        end
        run_eval(3'd2, to);
        vectors++;
        if (regS !== 16'd13) begin
            miscompares++;
            $display("[TB] FAIL midreset_rerun: got %0d expected 13", regS);
        end
    endtask

    task automatic test_back_to_back();
        bit tracking = 1'b0;
        int gap  = 0;
        int runs = 0;
        clear_stats();
        start = 1'b1;
        x_in  = 3'd1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done) begin
                runs++;
                vectors++;
                if (regS !== 16'd5) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_result: got %0d expected 5", regS);
                end
                tracking = 1'b1;
                gap = 0;
            end else if (tracking) begin
                if (ld_x) begin
                    vectors++;
                    if (gap != 1) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_gap: got %0d idle cycles expected 1", gap);
                    end
                    tracking = 1'b0;
                end else begin
                    gap++;
                end
            end
        end
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (!busy && !done) break;
        end
        vectors++;
        if (runs < 3) begin
            miscompares++;
            $display("[TB] FAIL b2b_runs: got %0d expected at least 3", runs);
        end
    endtask

    task automatic test_random();
        bit to;
        logic [2:0] x;
        for (int n = 0; n < 6; n++) begin
            kA = 16'($urandom);
            kB = 16'($urandom);
            kC = 16'($urandom);
            x  = 3'($urandom_range(0, 7));
            run_eval(x, to);
            vectors++;
            if (regS !== poly(kA, kB, kC, int'(x))) begin
                miscompares++;
                $display("[TB] FAIL rand_result: x=%0d got %h expected %h", x, regS, poly(kA, kB, kC, int'(x)));
            end
            vectors++;
            if (busyCnt != 7 + 2 * int'(x)) begin
                miscompares++;
                $display("[TB] FAIL rand_busy: x=%0d got %0d expected %0d", x, busyCnt, 7 + 2 * int'(x));
            end
        end
        kA = 16'd2;
        kB = 16'd2;
        kC = 16'd1;
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_x3();
        test_x0();
        test_x7();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        vectors++;
        if (onehotViol != 0) begin
            miscompares++;
            $display("[TB] FAIL onehot_loads: got %0d multi-load cycles expected 0", onehotViol);
        end
        vectors++;
        if (subSeen != 0) begin
            miscompares++;
            $display("[TB] FAIL sub_tied: got %0d cycles with sub expected 0", subSeen);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
